// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle word-addressed data memory for the MEM stage.
// The MEM stage holds a request; this block accepts it in IDLE, waits a fixed
// service latency, commits stores or captures load data on the edge that
// enters RESP, and pulses ack_o for one cycle. stall_o feeds the hazard logic.
// Optional feature macro: DATA_MEM_RESPONDER_ALIGN_CHECK_EN (misalignment
// reporting on err_o; misaligned requests then do not touch memory or rdata_o).
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               mis_q, mis_d;
  logic [31:0]        rdata_q, rdata_d;

  // Memory contents survive reset, so the array has no reset path.
  logic [31:0]        mem [DEPTH];

  logic [IDX_W-1:0]   req_idx;
  logic               req_mis;
  logic               go_resp;
  logic               c_we;
  logic [IDX_W-1:0]   c_idx;
  logic [31:0]        c_wdata;
  logic               c_mis;
  logic               mem_we;

  assign req_idx = addr_i[IDX_W+1:2];

`ifdef DATA_MEM_RESPONDER_ALIGN_CHECK_EN
  logic unused_addr_bits;
  assign req_mis          = |addr_i[1:0];
  assign unused_addr_bits = ^addr_i[31:IDX_W+2];
`else
  logic unused_addr_bits;
  assign req_mis          = 1'b0;
  assign unused_addr_bits = ^{addr_i[31:IDX_W+2], addr_i[1:0]};
`endif

  // Next-state, counter and request-capture logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    go_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          idx_d   = req_idx;
          wdata_d = wdata_i;
          mis_d   = req_mis;
          cnt_d   = CNT_INIT;
          if (LATENCY == 1) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // req_i is ignored here; a held request is re-seen in the next IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Commit operand select: with single-cycle latency the commit happens on the
  // accept edge itself, so the live inputs are used instead of the latched copy.
  always_comb begin
    c_we    = we_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    c_mis   = mis_q;
    if (state_q == IDLE) begin
      c_we    = we_i;
      c_idx   = req_idx;
      c_wdata = wdata_i;
      c_mis   = req_mis;
    end
    mem_we  = go_resp & c_we & ~c_mis & rst_i;
    rdata_d = rdata_q;
    if (go_resp && !c_we && !c_mis) begin
      rdata_d = mem[c_idx];
    end
  end

  // Control and load-data registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      mis_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  // Store commit into the memory array on the edge that enters RESP.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[c_idx] <= c_wdata;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign ack_o   = (state_q == RESP);
  assign rdata_o = rdata_q;
  assign err_o   = ack_o & mis_q;
  assign stall_o = req_i & ~ack_o;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances cover LATENCY 2, 1
// and 3. Expected values are hand-computed constants; the misalignment
// expectations follow DATA_MEM_RESPONDER_ALIGN_CHECK_EN when it is defined.
module tb_data_mem_responder;

`ifdef DATA_MEM_RESPONDER_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req   [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        ready [3];
  logic        ack   [3];
  logic [31:0] rdata [3];
  logic        err   [3];
  logic        stall [3];

  int n_checks = 0;
  int n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(1024), .LATENCY(2)) u_lat2 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .ready_o(ready[0]), .ack_o(ack[0]), .rdata_o(rdata[0]),
    .err_o(err[0]), .stall_o(stall[0]));

  data_mem_responder #(.DEPTH(1024), .LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .ready_o(ready[1]), .ack_o(ack[1]), .rdata_o(rdata[1]),
    .err_o(err[1]), .stall_o(stall[1]));

  data_mem_responder #(.DEPTH(1024), .LATENCY(3)) u_lat3 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]),
    .wdata_i(wdata[2]), .ready_o(ready[2]), .ack_o(ack[2]), .rdata_o(rdata[2]),
    .err_o(err[2]), .stall_o(stall[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request on instance d from IDLE and wait for its ack.
  // lat counts negedges after the accept edge up to and including the ack one.
  task automatic do_req(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat, output int stalls,
                        output logic stall_in_ack);
    bit got_ack;
    @(negedge clk);
    chk($sformatf("ready_before_req%0d", d), 32'(ready[d]), 32'd1);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    #1;
    stalls  = stall[d] ? 1 : 0;
    lat     = 0;
    got_ack = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (ack[d]) begin
        got_ack = 1'b1;
        break;
      end
      if (stall[d]) stalls++;
      // Inputs must be ignored while the request is in service.
      addr[d]  = 32'hFFFF_FFFC;
      wdata[d] = 32'h0;
    end
    if (!got_ack) chk($sformatf("ack_timeout%0d", d), 32'd0, 32'd1);
    rd           = rdata[d];
    er           = err[d];
    stall_in_ack = stall[d];
    req[d]       = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        sia;
    int          lat;
    int          st;
    bit          ack_seen;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready[0]), 32'd1);
    chk("rst_ack",   32'(ack[0]),   32'd0);
    chk("rst_rdata", rdata[0],      32'd0);
    chk("rst_err",   32'(err[0]),   32'd0);
    chk("rst_stall", 32'(stall[0]), 32'd0);
    rst_n = 1'b1;

    // LATENCY 2: store then load the same word.
    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat, st, sia);
    chk("l2_st_lat",   32'(lat), 32'd2);
    chk("l2_st_stall", 32'(st),  32'd2);
    chk("l2_st_sia",   32'(sia), 32'd0);
    chk("l2_st_err",   32'(er),  32'd0);
    do_req(0, 1'b0, 32'h10, 32'h0, rd, er, lat, st, sia);
    chk("l2_ld_lat",   32'(lat), 32'd2);
    chk("l2_ld_stall", 32'(st),  32'd2);
    chk("l2_ld_data",  rd,       32'hDEAD_BEEF);
    @(negedge clk);
    chk("l2_ack_one_cycle", 32'(ack[0]), 32'd0);

    // LATENCY 1: index wrap-around (0x1000 aliases word 0 with DEPTH 1024).
    do_req(1, 1'b1, 32'h0, 32'h1111_1111, rd, er, lat, st, sia);
    chk("l1_st0_lat", 32'(lat), 32'd1);
    do_req(1, 1'b1, 32'h1000, 32'h2222_2222, rd, er, lat, st, sia);
    chk("l1_st1_lat",   32'(lat), 32'd1);
    chk("l1_st1_stall", 32'(st),  32'd1);
    do_req(1, 1'b0, 32'h0, 32'h0, rd, er, lat, st, sia);
    chk("l1_wrap_data", rd, 32'h2222_2222);

    // A store leaves rdata_o holding the last load result.
    do_req(0, 1'b1, 32'h20, 32'h0000_1234, rd, er, lat, st, sia);
    do_req(0, 1'b0, 32'h20, 32'h0, rd, er, lat, st, sia);
    chk("hold_ld_data", rd, 32'h0000_1234);
    do_req(0, 1'b1, 32'h24, 32'h5555_AAAA, rd, er, lat, st, sia);
    chk("hold_in_ack", rd, 32'h0000_1234);
    @(negedge clk);
    chk("hold_after_ack", rdata[0], 32'h0000_1234);
    do_req(0, 1'b0, 32'h24, 32'h0, rd, er, lat, st, sia);
    chk("ld_0x24", rd, 32'h5555_AAAA);

    // Misaligned store to 0x13 and misaligned load of 0x21.
    do_req(0, 1'b1, 32'h13, 32'hCAFE_F00D, rd, er, lat, st, sia);
    chk("mis_st_err", 32'(er),  32'(ALIGN));
    chk("mis_st_lat", 32'(lat), 32'd2);
    do_req(0, 1'b0, 32'h10, 32'h0, rd, er, lat, st, sia);
    chk("mis_word10", rd, ALIGN ? 32'hDEAD_BEEF : 32'hCAFE_F00D);
    chk("mis_ld10_err", 32'(er), 32'd0);
    do_req(0, 1'b0, 32'h21, 32'h0, rd, er, lat, st, sia);
    chk("mis_ld_err",  32'(er), 32'(ALIGN));
    chk("mis_ld_data", rd, ALIGN ? (ALIGN ? 32'hCAFE_F00D & 32'h0 | 32'hDEAD_BEEF : 32'h0) : 32'h0000_1234);

    // LATENCY 3: reset during BUSY discards the pending store.
    do_req(2, 1'b1, 32'h40, 32'hAAAA_0000, rd, er, lat, st, sia);
    chk("l3_st_lat",   32'(lat), 32'd3);
    chk("l3_st_stall", 32'(st),  32'd3);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'hBBBB_0000;
    @(negedge clk);
    chk("l3_busy_ready", 32'(ready[2]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready[2]), 32'd1);
    chk("midrst_ack",   32'(ack[2]),   32'd0);
    chk("midrst_rdata", rdata[0],      32'd0);
    chk("midrst_err",   32'(err[0]),   32'd0);
    ack_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack[2]) ack_seen = 1'b1;
    end
    chk("midrst_no_ack", 32'(ack_seen), 32'd0);
    req[2] = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready[2]), 32'd1);
    chk("post_rst_ack",   32'(ack[2]),   32'd0);
    do_req(2, 1'b0, 32'h40, 32'h0, rd, er, lat, st, sia);
    chk("l3_old_data", rd, 32'hAAAA_0000);
    do_req(0, 1'b0, 32'h10, 32'h0, rd, er, lat, st, sia);
    chk("persist_0x10", rd, ALIGN ? 32'hDEAD_BEEF : 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
